// File: rtl/dvi_in_rst_pkg.sv
// Shared types and sizing helpers for the DVI input reset sequencer.
// The state enum is also decoded by status/CSR blocks.
package dvi_in_rst_pkg;

  typedef enum logic [1:0] {
    HOLD      = 2'd0,
    WAIT_LOCK = 2'd1,
    RELEASE   = 2'd2,
    RUN       = 2'd3
  } rst_seq_state_t;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

  function automatic int clog2_min1(input int v);
    return (v <= 2) ? 1 : $clog2(v);
  endfunction

endpackage

// File: rtl/dvi_in_rst_timer.sv
// Load/decrement down-counter shared by all sequencer states.
// Stops at zero; load takes priority over decrement.
module dvi_in_rst_timer #(
  parameter int W = 8
) (
  input  logic         pclk1x,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         zero
);

  logic [W-1:0] cnt;

  always_ff @(posedge pclk1x) begin
    if (load)
      cnt <= load_val;
    else if (dec && cnt != '0)
      cnt <= cnt - 1'b1;
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/dvi_in_reset_seq.sv
// Staged reset sequencer for the DVI/HDMI input path (pclk1x domain).
// Holds resets while unlocked or on request, then releases stages in order.
module dvi_in_reset_seq
  import dvi_in_rst_pkg::*;
#(
  parameter int NUM_STAGES  = 3,
  parameter int HOLD_CYCLES = 255,
  parameter int LOCK_STABLE = 64,
  parameter int STAGE_GAP   = 16,
  parameter int LOSS_CNT_W  = 8
) (
  input  logic                  pclk1x,
  input  logic                  rst,
  input  logic                  rst_request,
  input  logic                  locked,
  output logic [NUM_STAGES-1:0] rst_out,
  output logic                  ready,
  output logic [1:0]            state,
  output logic [LOSS_CNT_W-1:0] lock_loss_cnt
);

  if (NUM_STAGES < 1 || HOLD_CYCLES < 1 || LOCK_STABLE < 1 ||
      STAGE_GAP < 1 || LOSS_CNT_W < 1) begin : g_param_err
    $error("dvi_in_reset_seq: parameter below minimum");
  end

  localparam int CNT_W =
    clog2_min1(max3(HOLD_CYCLES, LOCK_STABLE, STAGE_GAP));
  localparam int STG_W =
    (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1;

  localparam logic [CNT_W-1:0] HOLD_LD = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] LOCK_LD = CNT_W'(LOCK_STABLE - 1);
  localparam logic [CNT_W-1:0] GAP_LD  = CNT_W'(STAGE_GAP - 1);
  localparam logic [STG_W-1:0] LAST    = STG_W'(NUM_STAGES - 1);

  rst_seq_state_t          state_q, state_d;
  logic [STG_W-1:0]        stage_q, stage_d;
  logic [NUM_STAGES-1:0]   rst_q, rst_d;
  logic                    ready_q, ready_d;
  logic [LOSS_CNT_W-1:0]   loss_q, loss_d;

  logic             abort;
  logic             t_load, t_dec, t_zero;
  logic [CNT_W-1:0] t_val;

  dvi_in_rst_timer #(
    .W (CNT_W)
  ) u_timer (
    .pclk1x   (pclk1x),
    .load     (rst | t_load),
    .load_val (rst ? HOLD_LD : t_val),
    .dec      (t_dec),
    .zero     (t_zero)
  );

  assign abort = rst_request | ~locked;

  always_ff @(posedge pclk1x) begin
    if (rst) begin
      state_q <= HOLD;
      stage_q <= '0;
      rst_q   <= '1;
      ready_q <= 1'b0;
      loss_q  <= '0;
    end else begin
      state_q <= state_d;
      stage_q <= stage_d;
      rst_q   <= rst_d;
      ready_q <= ready_d;
      loss_q  <= loss_d;
    end
  end

  always_comb begin
    state_d = state_q;
    stage_d = stage_q;
    rst_d   = rst_q;
    ready_d = ready_q;
    loss_d  = loss_q;
    t_load  = 1'b0;
    t_val   = HOLD_LD;
    t_dec   = 1'b0;
    if (abort) begin
      state_d = HOLD;
      t_load  = 1'b1;
      t_val   = HOLD_LD;
      rst_d   = '1;
      ready_d = 1'b0;
      // only a lock loss out of RUN is an event worth counting
      if (state_q == RUN && !locked && loss_q != '1)
        loss_d = loss_q + 1'b1;
    end else begin
      unique case (state_q)
        HOLD: begin
          if (t_zero) begin
            state_d = WAIT_LOCK;
            t_load  = 1'b1;
            t_val   = LOCK_LD;
          end else begin
            t_dec = 1'b1;
          end
        end
        WAIT_LOCK: begin
          if (t_zero) begin
            rst_d[0] = 1'b0;
            if (NUM_STAGES == 1) begin
              state_d = RUN;
              ready_d = 1'b1;
            end else begin
              state_d = RELEASE;
              stage_d = STG_W'(1);
              t_load  = 1'b1;
              t_val   = GAP_LD;
            end
          end else begin
            t_dec = 1'b1;
          end
        end
        RELEASE: begin
          if (t_zero) begin
            for (int k = 0; k < NUM_STAGES; k++)
              if (STG_W'(k) == stage_q)
                rst_d[k] = 1'b0;
            if (stage_q == LAST) begin
              state_d = RUN;
              ready_d = 1'b1;
            end else begin
              stage_d = stage_q + 1'b1;
              t_load  = 1'b1;
              t_val   = GAP_LD;
            end
          end else begin
            t_dec = 1'b1;
          end
        end
        RUN: begin
          rst_d   = '0;
          ready_d = 1'b1;
        end
        default: state_d = HOLD;
      endcase
    end
  end

  assign rst_out       = rst_q;
  assign ready         = ready_q;
  assign state         = state_q;
  assign lock_loss_cnt = loss_q;

endmodule

// File: tb/tb_dvi_in_reset_seq.sv
// Bench for dvi_in_reset_seq: three instances share one stimulus stream.
// Expected events are queued against edge numbers and checked at negedge.
module tb_dvi_in_reset_seq;

  localparam int HC  = 8;
  localparam int LS  = 4;
  localparam int SG  = 2;
  localparam int SEQ = HC + LS;

  localparam int RO   = 0;
  localparam int RDY  = 1;
  localparam int ST   = 2;
  localparam int CNT  = 3;
  localparam int SCNT = 4;
  localparam int ORO  = 5;
  localparam int ORDY = 6;

  logic pclk1x = 1'b0;
  logic rst = 1'b1;
  logic rst_request = 1'b0;
  logic locked = 1'b1;

  logic [2:0] rst_out;
  logic       ready;
  logic [1:0] state;
  logic [7:0] cnt;
  logic [2:0] s_rst_out;
  logic       s_ready;
  logic [1:0] s_state;
  logic [1:0] s_cnt;
  logic [0:0] o_rst_out;
  logic       o_ready;
  logic [1:0] o_state;
  logic [7:0] o_cnt;

  always #5 pclk1x = ~pclk1x;

  dvi_in_reset_seq #(
    .NUM_STAGES(3), .HOLD_CYCLES(HC), .LOCK_STABLE(LS),
    .STAGE_GAP(SG), .LOSS_CNT_W(8)
  ) dut (
    .pclk1x(pclk1x), .rst(rst), .rst_request(rst_request),
    .locked(locked), .rst_out(rst_out), .ready(ready),
    .state(state), .lock_loss_cnt(cnt)
  );

  dvi_in_reset_seq #(
    .NUM_STAGES(3), .HOLD_CYCLES(HC), .LOCK_STABLE(LS),
    .STAGE_GAP(SG), .LOSS_CNT_W(2)
  ) dut_sat (
    .pclk1x(pclk1x), .rst(rst), .rst_request(rst_request),
    .locked(locked), .rst_out(s_rst_out), .ready(s_ready),
    .state(s_state), .lock_loss_cnt(s_cnt)
  );

  dvi_in_reset_seq #(
    .NUM_STAGES(1), .HOLD_CYCLES(HC), .LOCK_STABLE(LS),
    .STAGE_GAP(SG), .LOSS_CNT_W(8)
  ) dut_one (
    .pclk1x(pclk1x), .rst(rst), .rst_request(rst_request),
    .locked(locked), .rst_out(o_rst_out), .ready(o_ready),
    .state(o_state), .lock_loss_cnt(o_cnt)
  );

  typedef struct {
    int cyc;
    int sel;
    int val;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  int   loss = 0;
  int   last_a = 0;

  always @(posedge pclk1x) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s @edge %0d: got %0d expected %0d",
               tag, cyc, got, exp);
    end
  endtask

  function automatic string nm(input int s);
    case (s)
      RO:      return "rst_out";
      RDY:     return "ready";
      ST:      return "state";
      CNT:     return "lock_loss_cnt";
      SCNT:    return "sat_lock_loss_cnt";
      ORO:     return "one_rst_out";
      default: return "one_ready";
    endcase
  endfunction

  function automatic logic [31:0] obs(input int s);
    case (s)
      RO:      return {29'b0, rst_out};
      RDY:     return {31'b0, ready};
      ST:      return {30'b0, state};
      CNT:     return {24'b0, cnt};
      SCNT:    return {30'b0, s_cnt};
      ORO:     return {31'b0, o_rst_out};
      default: return {31'b0, o_ready};
    endcase
  endfunction

  always @(negedge pclk1x) begin
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].cyc == cyc) begin
        check(nm(sb[i].sel), obs(sb[i].sel), sb[i].val);
        sb.delete(i);
      end
    end
  end

  task automatic push(input int c, input int s, input int v);
    exp_t e;
    e.cyc = c;
    e.sel = s;
    e.val = v;
    sb.push_back(e);
  endtask

  task automatic flush_from(input int c);
    for (int i = sb.size() - 1; i >= 0; i--)
      if (sb[i].cyc >= c) sb.delete(i);
  endtask

  task automatic goto(input int c);
    while (cyc < c) begin
      @(posedge pclk1x);
      #1;
    end
  endtask

  // expected release timeline after the last abort/reset edge a
  task automatic seq(input int a);
    int sat;
    sat = (loss > 3) ? 3 : loss;
    last_a = a;
    push(a, RO, 7);
    push(a, RDY, 0);
    push(a, ST, 0);
    push(a, ORO, 1);
    push(a, ORDY, 0);
    push(a + SEQ - 1, RO, 7);
    push(a + SEQ - 1, ST, 1);
    push(a + SEQ - 1, ORO, 1);
    push(a + SEQ - 1, ORDY, 0);
    push(a + SEQ, ORO, 0);
    push(a + SEQ, ORDY, 1);
    for (int k = 0; k < 3; k++) begin
      if (k > 0) push(a + SEQ + k * SG - 1, RO, (7 << k) & 7);
      push(a + SEQ + k * SG, RO, (7 << (k + 1)) & 7);
    end
    push(a + SEQ + 2 * SG - 1, RDY, 0);
    push(a + SEQ + 2 * SG, RDY, 1);
    push(a + SEQ + 2 * SG, ST, 3);
    push(a + SEQ + 2 * SG, CNT, loss);
    push(a + SEQ + 2 * SG, SCNT, sat);
  endtask

  // kind 0: locked low, 1: rst_request, 2: rst; held len cycles
  task automatic pulse(input int kind, input int len, input bit in_run);
    int c;
    int e;
    c = cyc;
    e = c + 1;
    flush_from(e);
    if (kind == 0 && in_run) loss++;
    if (kind == 2) loss = 0;
    case (kind)
      0:       locked = 1'b0;
      1:       rst_request = 1'b1;
      default: rst = 1'b1;
    endcase
    push(e, RO, 7);
    push(e, RDY, 0);
    push(e, ST, 0);
    push(e, CNT, loss);
    push(e, SCNT, (loss > 3) ? 3 : loss);
    if (len > 2) begin
      push(e + len / 2, RO, 7);
      push(e + len / 2, ORO, 1);
      push(e + len / 2, CNT, loss);
    end
    goto(c + len);
    locked = 1'b1;
    rst_request = 1'b0;
    rst = 1'b0;
    seq(c + len);
  endtask

  initial begin
    goto(3);
    rst = 1'b0;
    push(3, CNT, 0);
    push(3, SCNT, 0);
    seq(3);
    goto(last_a + 17);

    pulse(2, 2, 1'b0);
    goto(last_a + 9);
    pulse(0, 1, 1'b0);
    goto(last_a + 17);

    pulse(0, 3, 1'b1);
    goto(last_a + 17);

    pulse(1, 1, 1'b0);
    goto(last_a + 17);

    for (int n = 0; n < 4; n++) begin
      pulse(0, 1, 1'b1);
      goto(last_a + 17);
    end

    pulse(1, 30, 1'b0);
    goto(last_a + 17);

    pulse(2, 1, 1'b0);
    goto(last_a + 17);

    check("scoreboard_drained", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
